// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 5-stage RV32IM pipeline. Owns the fetch PC,
//   drives the synchronous instruction SRAM and presents the instruction/PC to
//   decode. Applies the controller's pc_sel/instr_sel every cycle: sequential
//   fetch, redirect, load-use hold and NOP injection.
//
//   Optional feature macro: IF_MISALIGN_CHK_EN
//     defined   : a redirect whose br_target[1:0] != 0 sets the sticky
//                 misalign_err flag (cleared only by rst); the target is still
//                 fetched with its low bits cleared.
//     undefined : low bits are silently cleared, misalign_err tied 0.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous reset, active-high
//   pc_sel       in   00 PC+4, 01 redirect to br_target, 10/11 hold PC
//   instr_sel    in   00 SRAM data, 01 replay held instr, 10/11 inject NOP
//   br_target    in   redirect address
//   im_ceb       out  SRAM chip enable, active-low (always enabled)
//   im_addr      out  SRAM word address = next_pc[IM_AW+1:2] (combinational)
//   im_dout      in   SRAM read data, valid one cycle after im_addr
//   instr_d      out  instruction presented to decode (combinational)
//   pc_d         out  PC of instr_d
//   valid_d      out  instr_d is a real instruction (0 for injected NOPs)
//   pc_ex        out  pc_d registered, for PC-relative ALU ops
//   misalign_err out  sticky redirect-misalignment flag
// ----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IM_AW    = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pc_sel,
  input  logic [1:0]       instr_sel,
  input  logic [31:0]      br_target,
  output logic             im_ceb,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_dout,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic             valid_d,
  output logic [31:0]      pc_ex,
  output logic             misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_f_q;
  logic [31:0] next_pc_d;
  logic [31:0] instr_hold_q;
  logic [31:0] pc_hold_q;
  logic [31:0] pc_ex_q;

  // Next fetch address. In BOOT the SRAM has not produced data for pc_f yet,
  // so the same address is re-issued regardless of pc_sel.
  always_comb begin
    next_pc_d = pc_f_q;
    if (state_q != BOOT) begin
      case (pc_sel)
        2'b00:   next_pc_d = pc_f_q + 32'd4;
        2'b01:   next_pc_d = {br_target[31:2], 2'b00};
        default: next_pc_d = pc_f_q;
      endcase
    end
  end

  // During reset state_q is BOOT and pc_f_q is RESET_PC, so this already
  // presents RESET_PC to the SRAM without a separate reset path.
  assign im_addr = next_pc_d[IM_AW+1:2];
  assign im_ceb  = 1'b0;

  // Decode-side view; BOOT overrides instr_sel since im_dout is not yet valid.
  always_comb begin
    instr_d = NOP;
    pc_d    = pc_f_q;
    valid_d = 1'b0;
    if (state_q != BOOT) begin
      case (instr_sel)
        2'b00: begin
          instr_d = im_dout;
          pc_d    = pc_f_q;
          valid_d = 1'b1;
        end
        2'b01: begin
          instr_d = instr_hold_q;
          pc_d    = pc_hold_q;
          valid_d = 1'b1;
        end
        default: begin
          instr_d = NOP;
          pc_d    = pc_f_q;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign pc_ex = pc_ex_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_f_q       <= RESET_PC;
      instr_hold_q <= NOP;
      pc_hold_q    <= RESET_PC;
      pc_ex_q      <= '0;
    end else begin
      pc_f_q  <= next_pc_d;
      pc_ex_q <= pc_d;
      // Keep the pre-stall instruction/PC captured while holding so that a
      // replay after the stall returns exactly what decode saw before it.
      if (state_q != HOLD) begin
        instr_hold_q <= instr_d;
        pc_hold_q    <= pc_d;
      end
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     if (pc_sel[1]) state_q <= HOLD;
        HOLD:    if (!pc_sel[1]) state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if ((state_q != BOOT) && (pc_sel == 2'b01) &&
                 (br_target[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  logic unused_br_lsbs;
  assign unused_br_lsbs = ^br_target[1:0];
  assign misalign_err   = 1'b0;
`endif

endmodule
